// File: rtl/ethernet_frame_dropper_wide.sv
// AXI4-Stream frame dropper: discards whole frames when the rear FIFO is almost full at SOF.
// Optional pass_count output enabled by defining ETHERNET_FRAME_DROPPER_PASS_COUNT_EN.
module ethernet_frame_dropper_wide #(
   parameter int unsigned TDATA_WIDTH = 64,
   parameter int unsigned TUSER_WIDTH = 1,
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       drop_enable,
   input  logic                       fifo_is_almost_full,
   input  logic                       count_clear,
   input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   input  logic [TUSER_WIDTH-1:0]     s_axis_tuser,
   output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [TUSER_WIDTH-1:0]     m_axis_tuser,
`ifdef ETHERNET_FRAME_DROPPER_PASS_COUNT_EN
   output logic [COUNT_WIDTH-1:0]     pass_count,
`endif
   output logic [COUNT_WIDTH-1:0]     drop_count
);

   localparam int unsigned KeepWidth = TDATA_WIDTH / 8;
   localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

   localparam logic [1:0] StSof  = 2'd0;
   localparam logic [1:0] StPass = 2'd1;
   localparam logic [1:0] StDrop = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [TDATA_WIDTH-1:0] tdata_q;
   logic [KeepWidth-1:0]   tkeep_q;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q;
   logic [TUSER_WIDTH-1:0] tuser_q;
   logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

   logic stage_free;
   logic drop_now;
   logic ready;
   logic accept;
   logic fwd;
   logic drop_inc;
   logic pass_inc;

   assign stage_free = !tvalid_q || m_axis_tready;
   assign drop_now   = drop_enable && fifo_is_almost_full;
   assign accept     = s_axis_tvalid && ready;
   // Upstream is held off while in reset even though ready would otherwise be high.
   assign s_axis_tready = rstn && ready;

   always_comb begin
      state_d  = state_q;
      ready    = stage_free;
      fwd      = 1'b0;
      drop_inc = 1'b0;
      case (state_q)
         StSof: begin
            if (s_axis_tvalid && drop_now) begin
               ready = 1'b1;
               if (s_axis_tlast) begin
                  drop_inc = 1'b1;
               end else begin
                  state_d = StDrop;
               end
            end else if (accept) begin
               fwd = 1'b1;
               if (!s_axis_tlast) begin
                  state_d = StPass;
               end
            end
         end
         StPass: begin
            if (accept) begin
               fwd = 1'b1;
               if (s_axis_tlast) begin
                  state_d = StSof;
               end
            end
         end
         StDrop: begin
            ready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               drop_inc = 1'b1;
               state_d  = StSof;
            end
         end
         default: state_d = StSof;
      endcase
   end

   assign pass_inc = fwd && s_axis_tlast;

   always_comb begin
      tvalid_d = tvalid_q;
      if (fwd) begin
         tvalid_d = 1'b1;
      end else if (m_axis_tready) begin
         tvalid_d = 1'b0;
      end
   end

   always_comb begin
      drop_count_d = drop_count_q;
      if (count_clear) begin
         drop_count_d = '0;
      end else if (drop_inc && drop_count_q != '1) begin
         drop_count_d = drop_count_q + CountOne;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StSof;
         tdata_q      <= '0;
         tkeep_q      <= '0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         tuser_q      <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         tvalid_q     <= tvalid_d;
         drop_count_q <= drop_count_d;
         if (fwd) begin
            tdata_q <= s_axis_tdata;
            tkeep_q <= s_axis_tkeep;
            tlast_q <= s_axis_tlast;
            tuser_q <= s_axis_tuser;
         end
      end
   end

`ifdef ETHERNET_FRAME_DROPPER_PASS_COUNT_EN
   logic [COUNT_WIDTH-1:0] pass_count_q, pass_count_d;

   always_comb begin
      pass_count_d = pass_count_q;
      if (count_clear) begin
         pass_count_d = '0;
      end else if (pass_inc && pass_count_q != '1) begin
         pass_count_d = pass_count_q + CountOne;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pass_count_q <= '0;
      end else begin
         pass_count_q <= pass_count_d;
      end
   end

   assign pass_count = pass_count_q;
`else
   logic unused_pass_inc;
   assign unused_pass_inc = pass_inc;
`endif

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign drop_count    = drop_count_q;

endmodule
